pwm_gen_dt: RTL and testbench

PWM_GEN_DT -- requirements
Module: pwm_gen_dt

---
 rtl/pwm_gen_dt.sv | 142 ++++++++++++++
 tb/tb_pwm_gen_dt.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_dt.sv
// Complementary high/low-side PWM generator with dead time and period-boundary reload.
// Latency: pwm_hi/pwm_lo are registered, one cycle after the counter value they reflect.
// Backpressure: none; load is a single-cycle strobe whose values wait for the next boundary.
module pwm_gen_dt #(
  parameter int CNT_W      = 16,
  parameter int DT_W       = 8,
  parameter int RST_PERIOD = 40,
  parameter int RST_DUTY   = 20,
  parameter int RST_DT     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  deadtime,
  input  logic             load,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             pstart,
  output logic             upd
);

  localparam logic [CNT_W-1:0] P_RST = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] D_RST = CNT_W'(RST_DUTY);
  localparam logic [DT_W-1:0]  T_RST = DT_W'(RST_DT);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(2);

  // Period counter and active/pending configuration
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_p_act;
  logic [CNT_W-1:0] r_d_act;
  logic [DT_W-1:0]  r_t_act;
  logic [CNT_W-1:0] r_p_pend;
  logic [CNT_W-1:0] r_d_pend;
  logic [DT_W-1:0]  r_t_pend;
  logic             r_pend;

  // Dead-time run-length trackers and registered gate drives
  logic [DT_W-1:0]  r_run_hi;
  logic [DT_W-1:0]  r_run_lo;
  logic             r_pwm_hi;
  logic             r_pwm_lo;

  logic [CNT_W-1:0] w_p_eff;
  logic             w_wrap;
  logic             w_xfer;
  logic             w_raw;
  logic             w_hi_ok;
  logic             w_lo_ok;

  // Periods of 0 or 1 cannot hold both phases, so they run as 2
  assign w_p_eff = (r_p_act < P_MIN) ? P_MIN : r_p_act;
  assign w_wrap  = enable && (r_cnt == (w_p_eff - CNT_W'(1)));
  // Pending values move to active at a wrap, or straight away while stopped
  assign w_xfer  = r_pend && (w_wrap || !enable);
  // Unsigned compare: duty 0 never high, duty >= period always high
  assign w_raw   = enable && (r_cnt < r_d_act);
  // A run is long enough once it has already covered the dead time
  assign w_hi_ok = (r_run_hi >= r_t_act);
  assign w_lo_ok = (r_run_lo >= r_t_act);

  assign pwm_hi = r_pwm_hi;
  assign pwm_lo = r_pwm_lo;
  assign upd    = w_xfer;
  // reset_n gates pstart so it stays quiet while reset is held with enable high
  assign pstart = reset_n && enable && (r_cnt == '0);

  // Counter runs 0..P-1 while enabled and parks at 0 when stopped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture requested values; a later load simply overwrites the earlier one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_pend <= '0;
      r_d_pend <= '0;
      r_t_pend <= '0;
    end else if (load) begin
      r_p_pend <= period;
      r_d_pend <= duty;
      r_t_pend <= deadtime;
    end
  end

  // Pending flag: load wins over a same-cycle transfer so it lands at the following wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
    end else if (load) begin
      r_pend <= 1'b1;
    end else if (w_xfer) begin
      r_pend <= 1'b0;
    end
  end

  // Active values only change at a boundary (or while stopped), never mid-period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_act <= P_RST;
      r_d_act <= D_RST;
      r_t_act <= T_RST;
    end else if (w_xfer) begin
      r_p_act <= r_p_pend;
      r_d_act <= r_d_pend;
      r_t_act <= r_t_pend;
    end
  end

  // Gate drives: each side needs T+1 consecutive cycles of its raw phase; runs saturate at T
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_hi <= '0;
      r_run_lo <= '0;
      r_pwm_hi <= 1'b0;
      r_pwm_lo <= 1'b0;
    end else if (!enable) begin
      r_run_hi <= '0;
      r_run_lo <= '0;
      r_pwm_hi <= 1'b0;
      r_pwm_lo <= 1'b0;
    end else begin
      r_pwm_hi <= w_raw && w_hi_ok;
      r_pwm_lo <= !w_raw && w_lo_ok;
      if (w_raw) begin
        r_run_hi <= w_hi_ok ? r_t_act : (r_run_hi + DT_W'(1));
        r_run_lo <= '0;
      end else begin
        r_run_lo <= w_lo_ok ? r_t_act : (r_run_lo + DT_W'(1));
        r_run_hi <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen_dt.sv
// Bench for pwm_gen_dt: expected per-period (len, hi, lo, upd position) records are queued
// by the stimulus; a monitor measures each period between pstart pulses and compares.
// Windows that start while the queue is empty are measured but not checked.
module tb_pwm_gen_dt;

  localparam int CNT_W = 16;
  localparam int DT_W  = 8;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  deadtime;
  logic             load;
  logic             pwm_hi;
  logic             pwm_lo;
  logic             pstart;
  logic             upd;

  pwm_gen_dt #(
    .CNT_W(CNT_W), .DT_W(DT_W), .RST_PERIOD(40), .RST_DUTY(20), .RST_DT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period), .duty(duty),
    .deadtime(deadtime), .load(load), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .pstart(pstart), .upd(upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int hi;
    int lo;
    int upd;
  } win_t;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_overlap = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: measures each period between pstart pulses at the falling edge
  int m_len, m_hi, m_lo, m_upd, m_win;
  bit m_in, m_armed;
  initial begin
    m_in = 0; m_armed = 0; m_len = 0; m_hi = 0; m_lo = 0; m_upd = -1; m_win = 0;
  end

  always @(negedge clk) begin
    if (pwm_hi && pwm_lo) n_overlap++;
    if (!reset_n || !enable) begin
      m_in = 0;
    end else begin
      if (pstart) begin
        if (m_in && m_armed) begin
          win_t e;
          e = exp_q.pop_front();
          chk($sformatf("win%0d_len", m_win), m_len, e.len);
          chk($sformatf("win%0d_hi", m_win), m_hi, e.hi);
          chk($sformatf("win%0d_lo", m_win), m_lo, e.lo);
          chk($sformatf("win%0d_upd", m_win), m_upd, e.upd);
        end
        m_win++;
        m_in = 1;
        m_armed = (exp_q.size() > 0);
        m_len = 0; m_hi = 0; m_lo = 0; m_upd = -1;
      end
      if (m_in) begin
        if (upd) m_upd = m_len;
        m_len++;
        m_hi += int'(pwm_hi);
        m_lo += int'(pwm_lo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int len, input int hi, input int lo, input int u);
    win_t w;
    w.len = len; w.hi = hi; w.lo = lo; w.upd = u;
    exp_q.push_back(w);
  endtask

  task automatic do_load(input int p, input int d, input int t);
    period   = CNT_W'(p);
    duty     = CNT_W'(d);
    deadtime = DT_W'(t);
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  // Returns in the cycle after the next pstart, i.e. with the counter at 1
  task automatic sync_pstart();
    int n = 0;
    @(negedge clk);
    while (!pstart && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sync_pstart", int'(pstart), 1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; load = 1'b0;
    period = '0; duty = '0; deadtime = '0;
    repeat (2) tick();
    chk("rst_pwm_hi", int'(pwm_hi), 0);
    chk("rst_pwm_lo", int'(pwm_lo), 0);
    chk("rst_pstart", int'(pstart), 0);
    chk("rst_upd", int'(upd), 0);

    // Defaults 40/20/0: first period has one lo cycle fewer (outputs were in reset)
    push(40, 20, 19, -1); push(40, 20, 20, -1); push(40, 20, 20, -1);
    reset_n = 1'b1;
    drain();

    // Duty 10 loaded at counter 5: current period unchanged, upd at 39
    sync_pstart();
    push(40, 20, 20, 39); push(40, 10, 30, -1);
    sync_pstart();
    repeat (4) tick();
    do_load(40, 10, 0);
    drain();

    // Dead time 3 with 40/20: 17 high, 17 low, 6 both-low per period
    sync_pstart();
    push(40, 10, 30, 39); push(40, 17, 17, -1); push(40, 17, 17, -1);
    sync_pstart();
    do_load(40, 20, 3);
    drain();

    // Load on the wrap cycle is held over to the following wrap
    sync_pstart();
    push(40, 17, 17, -1); push(40, 17, 17, 39); push(40, 27, 7, -1);
    sync_pstart();
    repeat (38) tick();
    do_load(40, 30, 3);
    drain();

    // Duty 0 then duty 50 (> period) with dead time 3
    sync_pstart();
    push(40, 27, 7, 39); push(40, 0, 40, -1); push(40, 0, 40, 39);
    push(40, 36, 1, -1); push(40, 40, 0, -1);
    sync_pstart();
    do_load(40, 0, 3);
    sync_pstart();
    sync_pstart();
    do_load(40, 50, 3);
    drain();

    // Period 1 runs as 2
    sync_pstart();
    push(40, 40, 0, 39); push(2, 2, 0, -1); push(2, 1, 1, -1);
    sync_pstart();
    do_load(1, 1, 0);
    drain();

    // Period 0 runs as 2; loaded on a wrap cycle so it applies one period later
    sync_pstart();
    push(2, 1, 1, -1); push(2, 1, 1, 1); push(2, 1, 1, -1);
    sync_pstart();
    do_load(0, 1, 0);
    drain();

    // Disable: outputs quiet, load transfers next cycle with upd, restart honours dead time
    enable = 1'b0;
    tick();
    tick();
    chk("dis_pwm_hi", int'(pwm_hi), 0);
    chk("dis_pwm_lo", int'(pwm_lo), 0);
    chk("dis_pstart", int'(pstart), 0);
    do_load(40, 20, 3);
    chk("dis_upd_pulse", int'(upd), 1);
    tick();
    chk("dis_upd_clear", int'(upd), 0);
    push(40, 17, 16, -1); push(40, 17, 17, -1);
    enable = 1'b1;
    drain();

    // Asynchronous reset at counter 25 with a pending load outstanding
    sync_pstart();
    repeat (19) tick();
    do_load(40, 10, 5);
    repeat (4) tick();
    chk("pre_rst_pwm_lo", int'(pwm_lo), 1);
    chk("pre_rst_pwm_hi", int'(pwm_hi), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pwm_hi", int'(pwm_hi), 0);
    chk("arst_pwm_lo", int'(pwm_lo), 0);
    chk("arst_pstart", int'(pstart), 0);
    chk("arst_upd", int'(upd), 0);
    push(40, 20, 19, -1); push(40, 20, 20, -1);
    tick();
    tick();
    reset_n = 1'b1;
    drain();

    chk("no_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
